// File: rtl/prc_mc_ctrl.sv
// rtl/prc_mc_ctrl.sv - multi-partition reconfiguration controller: request queue, decouple sequencing, stream gating, status/IRQ
// Optional cycle counter register at 0x1C is built when PRC_PERF_EN is defined.
module prc_mc_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          NUM_RP       = 4,
  parameter int          DATA_WIDTH   = 32,
  parameter int          REQ_DEPTH    = 4,
  parameter int          DECOUPLE_CYC = 16,
  parameter int          TIMEOUT_W    = 24,
  parameter int          CNT_WIDTH    = 28
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wen,
  input  logic [31:0]             waddr,
  input  logic [31:0]             wdata,
  input  logic [7:0]              wstrb,
  output logic                    wrdy,
  input  logic                    ren,
  input  logic [31:0]             raddr,
  output logic [31:0]             rdata,
  output logic                    rrdy,
  input  logic                    s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  input  logic                    icap_done,
  input  logic                    icap_err,
  output logic [NUM_RP-1:0]       rp_decouple,
  output logic                    int_req
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DECOUPLE = 3'd1;
  localparam logic [2:0] S_STREAM   = 3'd2;
  localparam logic [2:0] S_FLUSH    = 3'd3;
  localparam logic [2:0] S_WAIT     = 3'd4;
  localparam logic [2:0] S_RECOUPLE = 3'd5;

  localparam int PTR_W  = $clog2(REQ_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int DC_W   = $clog2(DECOUPLE_CYC) + 1;
  localparam logic [FCNT_W-1:0] DEPTH_L  = FCNT_W'(REQ_DEPTH);
  localparam logic [DC_W-1:0]   DC_LAST  = DC_W'(DECOUPLE_CYC - 1);
  localparam logic [4:0]        NUM_RP_L = 5'(NUM_RP);

  logic [2:0]            r_state;
  logic [3:0]            r_ch;
  logic [NUM_RP-1:0]     r_decouple;
  logic [DC_W-1:0]       r_dc_cnt;
  logic [TIMEOUT_W-1:0]  r_to_cnt;
  logic [TIMEOUT_W-1:0]  r_timeout;
  logic [CNT_WIDTH-1:0]  r_beat_cnt;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic [NUM_RP-1:0]     r_done;
  logic [NUM_RP-1:0]     r_err;
  logic [1:0]            r_int_en;
  logic                  r_ovf;
  logic                  r_badch;
  logic                  r_int;
  logic                  r_wrdy;
  logic                  r_rrdy;
  logic [31:0]           r_rdata;
  logic [3:0]            r_fifo [REQ_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [FCNT_W-1:0]     r_count;

  logic [31:0]           w_woff;
  logic [31:0]           w_roff;
  logic                  w_wr;
  logic                  w_wr_ctrl;
  logic                  w_wr_status;
  logic                  w_wr_done;
  logic                  w_wr_err;
  logic                  w_push_req;
  logic                  w_ch_bad;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [3:0]            w_head;
  logic                  w_stream;
  logic                  w_flush;
  logic                  w_beat;
  logic                  w_to_exp;
  logic [NUM_RP-1:0]     w_cur_oh;
  logic                  w_set_done;
  logic                  w_set_err;
  logic                  w_busy;
  logic [31:0]           w_rmux;
  logic                  w_unused_ok;

  assign w_wr        = wen & (|wstrb);
  assign w_woff      = waddr - BASE_ADDR;
  assign w_roff      = raddr - BASE_ADDR;
  assign w_wr_ctrl   = w_wr && (w_woff == 32'h00);
  assign w_wr_status = w_wr && (w_woff == 32'h04);
  assign w_wr_done   = w_wr && (w_woff == 32'h08);
  assign w_wr_err    = w_wr && (w_woff == 32'h0C);
  assign w_unused_ok = &{1'b0, wdata};

  assign w_push_req = w_wr_ctrl & wdata[31];
  assign w_ch_bad   = ({1'b0, wdata[3:0]} >= NUM_RP_L);
  assign w_full     = (r_count == DEPTH_L);
  assign w_push     = w_push_req & ~w_ch_bad & ~w_full;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_head     = r_fifo[r_rptr];

  // Stream is only connected through in STREAM; FLUSH sinks the source without forwarding.
  assign w_stream      = (r_state == S_STREAM);
  assign w_flush       = (r_state == S_FLUSH);
  assign s_axis_tready = w_stream ? m_axis_tready : w_flush;
  assign m_axis_tvalid = w_stream & s_axis_tvalid;
  assign m_axis_tdata  = w_stream ? s_axis_tdata : '0;
  assign m_axis_tkeep  = w_stream ? s_axis_tkeep : '0;
  assign m_axis_tlast  = w_stream & s_axis_tlast;
  assign w_beat        = s_axis_tvalid & s_axis_tready;

  assign w_to_exp = (r_timeout != '0) && (r_to_cnt == r_timeout);
  assign w_cur_oh = NUM_RP'(1) << r_ch;
  assign w_busy   = (r_state != S_IDLE);

  assign w_set_done = (r_state == S_WAIT) && icap_done && !icap_err;
  assign w_set_err  = ((r_state == S_WAIT) && (icap_err || (w_to_exp && !icap_done)))
                    || (w_flush && w_beat && s_axis_tlast)
                    || (w_stream && w_beat && s_axis_tlast && icap_err);

  assign rp_decouple = r_decouple;
  assign int_req     = r_int;
  assign wrdy        = r_wrdy;
  assign rrdy        = r_rrdy;
  assign rdata       = r_rdata;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= wdata[3:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FCNT_W'(1);
        2'b01:   r_count <= r_count - FCNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_decouple <= '0;
      r_dc_cnt   <= '0;
      r_to_cnt   <= '0;
      r_beat_cnt <= '0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_ch       <= w_head;
            r_decouple <= NUM_RP'(1) << w_head;
            r_dc_cnt   <= '0;
            r_beat_cnt <= '0;
            r_state    <= S_DECOUPLE;
          end
        end
        S_DECOUPLE: begin
          if (r_dc_cnt == DC_LAST) begin
            r_dc_cnt <= '0;
            r_to_cnt <= '0;
            r_state  <= S_STREAM;
          end else begin
            r_dc_cnt <= r_dc_cnt + DC_W'(1);
          end
        end
        S_STREAM: begin
          if (w_beat) begin
            r_to_cnt <= '0;
            if (!(&r_beat_cnt)) r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
          end else if (!(&r_to_cnt)) begin
            r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
          end
          // An error coinciding with the final beat skips FLUSH: there is no tlast left to wait for.
          if (w_beat && s_axis_tlast) begin
            r_to_cnt <= '0;
            r_state  <= icap_err ? S_RECOUPLE : S_WAIT;
          end else if (icap_err || (w_to_exp && !w_beat)) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_beat && s_axis_tlast) begin
            r_dc_cnt <= '0;
            r_state  <= S_RECOUPLE;
          end
        end
        S_WAIT: begin
          if (icap_done || icap_err || w_to_exp) begin
            r_dc_cnt <= '0;
            r_state  <= S_RECOUPLE;
          end else if (!(&r_to_cnt)) begin
            r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
          end
        end
        S_RECOUPLE: begin
          if (r_dc_cnt == DC_LAST) begin
            r_dc_cnt   <= '0;
            r_decouple <= '0;
            r_word_cnt <= r_beat_cnt;
            r_state    <= S_IDLE;
          end else begin
            r_dc_cnt <= r_dc_cnt + DC_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky status: a hardware set in the same cycle as a W1C keeps the bit set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_done    <= '0;
      r_err     <= '0;
      r_int_en  <= '0;
      r_timeout <= '1;
      r_ovf     <= 1'b0;
      r_badch   <= 1'b0;
      r_int     <= 1'b0;
    end else begin
      r_done  <= (r_done & ~(w_wr_done ? wdata[NUM_RP-1:0] : '0)) | (w_set_done ? w_cur_oh : '0);
      r_err   <= (r_err & ~(w_wr_err ? wdata[NUM_RP-1:0] : '0)) | (w_set_err ? w_cur_oh : '0);
      r_ovf   <= (r_ovf & ~(w_wr_status & wdata[16])) | (w_push_req & ~w_ch_bad & w_full);
      r_badch <= (r_badch & ~(w_wr_status & wdata[17])) | (w_push_req & w_ch_bad);
      if (w_wr && (w_woff == 32'h10)) r_int_en <= wdata[1:0];
      if (w_wr && (w_woff == 32'h14)) r_timeout <= wdata[TIMEOUT_W-1:0];
      r_int <= (r_int_en[0] & (|r_done)) | (r_int_en[1] & (|r_err));
    end
  end

`ifdef PRC_PERF_EN
  logic [CNT_WIDTH-1:0] r_cyc_run;
  logic [CNT_WIDTH-1:0] r_cyc_cnt;
  logic [CNT_WIDTH-1:0] w_cyc_inc;

  assign w_cyc_inc = (&r_cyc_run) ? r_cyc_run : r_cyc_run + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cyc_run <= '0;
      r_cyc_cnt <= '0;
    end else if (w_pop) begin
      r_cyc_run <= '0;
    end else if (w_busy) begin
      r_cyc_run <= w_cyc_inc;
      if ((r_state == S_RECOUPLE) && (r_dc_cnt == DC_LAST)) r_cyc_cnt <= w_cyc_inc;
    end
  end
`endif

  always_comb begin
    w_rmux = '0;
    case (w_roff)
      32'h04: w_rmux = {14'd0, r_badch, r_ovf, 8'(r_count), r_ch, w_busy, r_state};
      32'h08: w_rmux = 32'(r_done);
      32'h0C: w_rmux = 32'(r_err);
      32'h10: w_rmux = {30'd0, r_int_en};
      32'h14: w_rmux = 32'(r_timeout);
      32'h18: w_rmux = 32'(r_word_cnt);
`ifdef PRC_PERF_EN
      32'h1C: w_rmux = 32'(r_cyc_cnt);
`endif
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wrdy  <= 1'b0;
      r_rrdy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_wrdy  <= wen;
      r_rrdy  <= ren;
      r_rdata <= ren ? w_rmux : '0;
    end
  end

endmodule

// File: tb/tb_prc_mc_ctrl.sv
// tb/tb_prc_mc_ctrl.sv - directed self-checking bench for prc_mc_ctrl
module tb_prc_mc_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wrdy;
  logic        ren = 1'b0;
  logic [31:0] raddr = '0;
  logic [31:0] rdata;
  logic        rrdy;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic        icap_done = 1'b0;
  logic        icap_err = 1'b0;
  logic [3:0]  rp_decouple;
  logic        int_req;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prc_mc_ctrl dut (
    .clk(clk), .resetn(resetn),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wrdy(wrdy),
    .ren(ren), .raddr(raddr), .rdata(rdata), .rrdy(rrdy),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .icap_done(icap_done), .icap_err(icap_err),
    .rp_decouple(rp_decouple), .int_req(int_req)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wen = 1'b1; waddr = a; wdata = d; wstrb = 8'hFF;
    @(negedge clk);
    wen = 1'b0; wstrb = 8'h00;
    chk("wrdy", {31'd0, wrdy}, 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    ren = 1'b1; raddr = a;
    @(negedge clk);
    ren = 1'b0;
    chk("rrdy", {31'd0, rrdy}, 32'd1);
    chk(tag, rdata, exp);
  endtask

  task automatic send_beats(input int n, input bit last, input bit pass, output int pre);
    int guard;
    pre = 0;
    for (int b = 0; b < n; b++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'hC0DE_0000 + b;
      s_tkeep  = 4'hF;
      s_tlast  = last && (b == n - 1);
      #1;
      guard = 0;
      while (!s_tready && guard < 300) begin
        if (b == 0 && rp_decouple != 4'd0) pre++;
        @(negedge clk); #1;
        guard++;
      end
      chk("beat_accept", {31'd0, s_tready}, 32'd1);
      chk("m_tvalid", {31'd0, m_tvalid}, {31'd0, pass});
      chk("m_tlast", {31'd0, m_tlast}, {31'd0, pass & s_tlast});
      if (pass) chk("m_tdata", m_tdata, s_tdata);
      @(negedge clk);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
  endtask

  task automatic pulse(input logic d, input logic e);
    icap_done = d; icap_err = e;
    @(negedge clk);
    icap_done = 1'b0; icap_err = 1'b0;
  endtask

  task automatic wait_clear(output int cyc);
    cyc = 0;
    while (rp_decouple != 4'd0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic serve(input int ch);
    int c;
    int pre;
    c = 0;
    while (rp_decouple == 4'd0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("serve_ch", {28'd0, rp_decouple}, 32'd1 << ch);
    send_beats(2, 1'b1, 1'b1, pre);
    pulse(1'b1, 1'b0);
    wait_clear(c);
    chk("serve_recouple", c, 32'd16);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pre;
    int cyc;
    logic seen;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", {m_tvalid, s_tready, m_tlast, int_req, wrdy, rrdy, rp_decouple}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mdata", m_tdata, 32'd0);
    resetn = 1'b1;
    rd_chk("rst_status", 32'h04, 32'h0000_0000);
    rd_chk("rst_timeout", 32'h14, 32'h00FF_FFFF);
    rd_chk("rst_done", 32'h08, 32'd0);
    rd_chk("rst_err", 32'h0C, 32'd0);
    rd_chk("rst_inten", 32'h10, 32'd0);
    rd_chk("rst_wordcnt", 32'h18, 32'd0);
    rd_chk("unmapped", 32'h40, 32'd0);
`ifndef PRC_PERF_EN
    rd_chk("cyc_absent", 32'h1C, 32'd0);
`endif

    // single request, channel 2, 8 beats
    m_tready = 1'b1;
    reg_wr(32'h00, 32'h8000_0002);
    send_beats(8, 1'b1, 1'b1, pre);
    chk("t1_pre_decouple", pre, 32'd16);
    chk("t1_dec_stream", {28'd0, rp_decouple}, 32'h4);
    pulse(1'b1, 1'b0);
    wait_clear(cyc);
    chk("t1_recouple_cyc", cyc, 32'd16);
    rd_chk("t1_done", 32'h08, 32'h4);
    rd_chk("t1_wordcnt", 32'h18, 32'd8);
    chk("t1_int", {31'd0, int_req}, 32'd0);

    // queue overflow and service order
    reg_wr(32'h00, 32'h8000_0000);
    cyc = 0;
    while (!s_tready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("t2_stream", {31'd0, s_tready}, 32'd1);
    reg_wr(32'h00, 32'h8000_0000);
    reg_wr(32'h00, 32'h8000_0001);
    reg_wr(32'h00, 32'h8000_0002);
    reg_wr(32'h00, 32'h8000_0003);
    reg_wr(32'h00, 32'h8000_0001);
    rd_chk("t2_status_ovf", 32'h04, 32'h0001_040A);
    reg_wr(32'h04, 32'h0001_0000);
    rd_chk("t2_status_clr", 32'h04, 32'h0000_040A);
    serve(0);
    serve(0);
    serve(1);
    serve(2);
    serve(3);
    rd_chk("t2_done", 32'h08, 32'hF);
    rd_chk("t2_wordcnt", 32'h18, 32'd2);
    rd_chk("t2_status_idle", 32'h04, 32'h0000_0030);

    // stream timeout, flush, error interrupt
    reg_wr(32'h14, 32'd100);
    reg_wr(32'h10, 32'd2);
    reg_wr(32'h00, 32'h8000_0001);
    send_beats(3, 1'b0, 1'b1, pre);
    m_tready = 1'b0;
    #1;
    cyc = 0;
    while (!s_tready && cyc < 300) begin
      cyc++;
      @(negedge clk); #1;
    end
    chk("t3_timeout_cyc", cyc, 32'd101);
    send_beats(2, 1'b1, 1'b0, pre);
    @(negedge clk);
    chk("t3_int_set", {31'd0, int_req}, 32'd1);
    rd_chk("t3_err", 32'h0C, 32'h2);
    rd_chk("t3_done_same", 32'h08, 32'hF);
    wait_clear(cyc);
    rd_chk("t3_wordcnt", 32'h18, 32'd3);
    reg_wr(32'h0C, 32'h2);
    @(negedge clk);
    chk("t3_int_clr", {31'd0, int_req}, 32'd0);
    rd_chk("t3_err_clr", 32'h0C, 32'd0);
    m_tready = 1'b1;

    // done and err together while waiting
    reg_wr(32'h08, 32'hF);
    rd_chk("t4_done_clr", 32'h08, 32'd0);
    reg_wr(32'h00, 32'h8000_0003);
    send_beats(1, 1'b1, 1'b1, pre);
    pulse(1'b1, 1'b1);
    rd_chk("t4_err", 32'h0C, 32'h8);
    rd_chk("t4_done", 32'h08, 32'h0);
    chk("t4_int", {31'd0, int_req}, 32'd1);
    wait_clear(cyc);

    // bad channel
    reg_wr(32'h00, 32'h8000_0007);
    rd_chk("t5_status_badch", 32'h04, 32'h0002_0030);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | (|rp_decouple);
    end
    chk("t5_no_decouple", {31'd0, seen}, 32'd0);
    reg_wr(32'h04, 32'h0002_0000);
    rd_chk("t5_badch_clr", 32'h04, 32'h0000_0030);

    // asynchronous reset mid-stream, then a fresh request
    reg_wr(32'h00, 32'h8000_0002);
    cyc = 0;
    while (!s_tready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    s_tvalid = 1'b1; s_tdata = 32'h1234_5678; s_tkeep = 4'hF;
    #1;
    chk("t6_pre_rst_valid", {31'd0, m_tvalid}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("t6_rst_outs", {m_tvalid, s_tready, m_tlast, int_req, wrdy, rrdy, rp_decouple}, 32'd0);
    chk("t6_rst_mdata", m_tdata, 32'd0);
    @(negedge clk);
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0;
    @(negedge clk);
    resetn = 1'b1;
    rd_chk("t6_timeout", 32'h14, 32'h00FF_FFFF);
    rd_chk("t6_err", 32'h0C, 32'd0);
    rd_chk("t6_status", 32'h04, 32'd0);
    reg_wr(32'h00, 32'h8000_0002);
    send_beats(4, 1'b1, 1'b1, pre);
    chk("t6_pre_decouple", pre, 32'd16);
    pulse(1'b1, 1'b0);
    wait_clear(cyc);
    chk("t6_recouple_cyc", cyc, 32'd16);
    rd_chk("t6_done", 32'h08, 32'h4);
    rd_chk("t6_wordcnt", 32'h18, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
